contador_tiempo: RTL and testbench
==================================

Name: contador_tiempo

Overview:
- hh:mm:ss timekeeping core of the digital clock.
- Sits directly downstream of the frequency divider and consumes its one-cycle 1 Hz `enable` tick.
- Holds seconds, minutes and hours as BCD digit pairs for the display stage.
- Provides a button-driven set mode for adjusting hours and minutes.

Parameters:
- HOURS_MOD, 24, hours modulus (field counts 0..HOURS_MOD-1); range 2..99.
- MINUTES_MOD, 60, minutes modulus; range 2..99.
- SECONDS_MOD, 60, seconds modulus; range 2..99. Reduced values allow fast simulation.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- enable  input  1  1 Hz tick from the frequency divider, high for exactly one clk cycle.
- btn_mode  input  1  debounced single-cycle pulse; advances the mode.
- btn_inc  input  1  debounced single-cycle pulse; increments the selected field.
- hour_tens  output  4  BCD tens digit of hours.
- hour_units  output  4  BCD units digit of hours.
- min_tens  output  4  BCD tens digit of minutes.
- min_units  output  4  BCD units digit of minutes.
- sec_tens  output  4  BCD tens digit of seconds.
- sec_units  output  4  BCD units digit of seconds.
- mode  output  2  current mode: 0 RUN, 1 SET_H, 2 SET_M.

Behaviour:
- Reset (reset=0): all digits 0 and mode RUN, applied asynchronously and held while low. Normal operation begins on the first rising clk edge after reset returns to 1.
- All outputs are registered. A qualifying input sampled high at edge N is reflected in the outputs after edge N; latency is 1 cycle.
- Each field is a two-digit BCD counter:
  - units 9 -> 0 carries into tens;
  - value MOD-1 wraps to 00;
  - wrap detection uses the full two-digit value.
- RUN mode, enable=1:
  - seconds +1;
  - seconds wrap -> minutes +1 in the same edge;
  - minutes wrap (coincident with seconds wrap) -> hours +1 in the same edge;
  - 23:59:59 -> 00:00:00, all six digits updating on one edge.
- RUN mode, btn_inc is ignored.
- State machine, advanced on btn_mode: RUN -> SET_H -> SET_M -> RUN.
- Entering SET_H clears seconds to 00 on the same edge.
- SET_H and SET_M:
  - enable is ignored and time is frozen;
  - btn_inc increments only the selected field (hours or minutes) modulo its MOD;
  - no carry into any other field.
- Leaving SET_M for RUN: seconds stay 00. Counting resumes on the next enable after the edge on which mode reads 0.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode change wins, inc discarded.
  - btn_mode and enable in RUN: go to SET_H, seconds cleared, tick discarded.
  - enable and btn_inc in a SET mode: inc applied, tick ignored.
- Reset mid-operation (any mode, any digits): immediate clear to 00:00:00, RUN. No partial increment survives.
- Pulses held high for multiple cycles act once per cycle high. Edge detection is upstream's responsibility.
- Mode encoding 3 is unreachable; if it ever occurs, the next edge returns to RUN.

Decomposition:
- Package `reloj_pkg`:
  - typedef enum logic [1:0] mode_t {MODE_RUN=0, MODE_SET_H=1, MODE_SET_M=2};
  - typedef struct packed {logic [3:0] tens; logic [3:0] units;} bcd2_t;
  - default modulus constants.
- Sub-module `bcd_mod_counter`:
  - parameter MOD;
  - inputs clk, reset, clr, inc;
  - outputs bcd2_t value and comb wrap (= inc && value==MOD-1).
- Instantiated three times. The top holds the mode FSM and the inc/clr steering.

Test Plan:
1. Hold reset=0 for 100 time units, then release; apply 5 enable pulses -> outputs 00:00:05, mode=0; after reset all digits are 0.
2. Set hours to 23 and minutes to 59 via SET modes, return to RUN, apply 59 enables -> 23:59:59; one more enable -> 00:00:00 with all digits changing on the same edge.
3. btn_mode three times with enable pulses interleaved during SET -> mode 1, 2, 0; time unchanged during SET; seconds read 00 on entering SET_H.
4. In SET_H, 25 btn_inc pulses from 00 -> hours 01 (wrap 23->00); minutes and seconds untouched.
5. In SET_H, btn_mode and btn_inc high in the same cycle -> mode=2, hours unchanged. In RUN, btn_mode coincident with enable -> mode=1, seconds=00.
6. Drive reset=0 asynchronously mid-cycle while in SET_M at 12:34 -> outputs 00:00:00 and mode=0 before the next clk edge; counting resumes normally after release.

Source files
------------

// File: rtl/reloj_pkg.sv
// Shared types and constants for the hh:mm:ss timekeeping core.
// BCD helpers are constant-evaluable so counters can derive their wrap value.
package reloj_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } mode_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  localparam int HOURS_MOD_DEF   = 24;
  localparam int MINUTES_MOD_DEF = 60;
  localparam int SECONDS_MOD_DEF = 60;

  function automatic bcd2_t to_bcd2(input int n);
    bcd2_t r;
    r.tens  = 4'(n / 10);
    r.units = 4'(n % 10);
    return r;
  endfunction

  // Plain two-digit BCD increment; modulus wrap is handled by the caller.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    if (v.units == 4'd9) begin
      r.tens  = v.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = v.tens;
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter counting 0..MOD-1 with synchronous clear.
// wrap is combinational and flags the increment that returns the field to 00.
module bcd_mod_counter
  import reloj_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clr,
  input  logic  inc,
  output bcd2_t value,
  output logic  wrap
);

  localparam bcd2_t LAST = to_bcd2(MOD - 1);

  // Compare both digits so reduced moduli (e.g. 7, 13) wrap correctly.
  assign wrap = inc && (value == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? bcd2_t'('0) : bcd2_inc(value);
    end
  end

endmodule

// File: rtl/contador_tiempo.sv
// hh:mm:ss timekeeping core: mode FSM (RUN/SET_H/SET_M) steering the
// increment and clear strobes of three BCD modulus counters.
module contador_tiempo
  import reloj_pkg::*;
#(
  parameter int HOURS_MOD   = HOURS_MOD_DEF,
  parameter int MINUTES_MOD = MINUTES_MOD_DEF,
  parameter int SECONDS_MOD = SECONDS_MOD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [1:0] mode
);

  // All inputs are single-cycle strobes with no handshake: each cycle a
  // strobe is sampled high counts as one event; upstream owns edge detection.

  mode_t mode_q;

  bcd2_t hours, minutes, seconds;
  logic  sec_inc, min_inc, hour_inc, sec_clr;
  logic  sec_wrap, min_wrap, unused_hour_wrap;
  logic  in_run, in_set_h, in_set_m, set_inc;

  assign in_run   = (mode_q == MODE_RUN);
  assign in_set_h = (mode_q == MODE_SET_H);
  assign in_set_m = (mode_q == MODE_SET_M);

  // A mode change always wins: it swallows both the tick and the button.
  assign set_inc  = btn_inc && !btn_mode;
  assign sec_inc  = in_run && enable && !btn_mode;
  assign sec_clr  = in_run && btn_mode;
  assign min_inc  = (in_run && sec_wrap) || (in_set_m && set_inc);
  assign hour_inc = (in_run && sec_wrap && min_wrap) || (in_set_h && set_inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_RUN;
    end else begin
      case (mode_q)
        MODE_RUN:   if (btn_mode) mode_q <= MODE_SET_H;
        MODE_SET_H: if (btn_mode) mode_q <= MODE_SET_M;
        MODE_SET_M: if (btn_mode) mode_q <= MODE_RUN;
        default:    mode_q <= MODE_RUN;
      endcase
    end
  end

  bcd_mod_counter #(.MOD(SECONDS_MOD)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clr   (sec_clr),
    .inc   (sec_inc),
    .value (seconds),
    .wrap  (sec_wrap)
  );

  bcd_mod_counter #(.MOD(MINUTES_MOD)) u_min (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (min_inc),
    .value (minutes),
    .wrap  (min_wrap)
  );

  // Hours have no downstream field, so their wrap is not consumed.
  bcd_mod_counter #(.MOD(HOURS_MOD)) u_hour (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (hour_inc),
    .value (hours),
    .wrap  (unused_hour_wrap)
  );

  assign hour_tens  = hours.tens;
  assign hour_units = hours.units;
  assign min_tens   = minutes.tens;
  assign min_units  = minutes.units;
  assign sec_tens   = seconds.tens;
  assign sec_units  = seconds.units;
  assign mode       = mode_q;

endmodule

// File: tb/tb_contador_tiempo.sv
// Directed bench for contador_tiempo: set mode, rollover, simultaneous
// strobes and asynchronous reset, each checked against hand-computed values.
module tb_contador_tiempo;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;
  logic [1:0] mode;
  logic [23:0] now_t;

  int n_cmp;
  int n_bad;

  contador_tiempo dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .hour_tens  (hour_tens),
    .hour_units (hour_units),
    .min_tens   (min_tens),
    .min_units  (min_units),
    .sec_tens   (sec_tens),
    .sec_units  (sec_units),
    .mode       (mode)
  );

  assign now_t = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one cycle of strobes, returns 1 time unit after the sampling edge
  task automatic pulse(input logic en, input logic bm, input logic bi);
    enable   = en;
    btn_mode = bm;
    btn_inc  = bi;
    @(posedge clk);
    #1;
    enable   = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    enable = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    #100;
    n_cmp++;
    if (now_t !== 24'h000000) begin
      n_bad++; $display("FAIL reset_time got %h want 000000", now_t);
    end
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++; $display("FAIL reset_mode got %0d want 0", mode);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b0);
    end
    n_cmp++;
    if (now_t !== 24'h000005 || mode !== 2'd0) begin
      n_bad++; $display("FAIL five_ticks got %h mode %0d want 000005 mode 0", now_t, mode);
    end
  endtask

  task automatic test_set_and_rollover;
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (now_t !== 24'h000000 || mode !== 2'd1) begin
      n_bad++; $display("FAIL enter_set_h got %h mode %0d want 000000 mode 1", now_t, mode);
    end
    for (int i = 0; i < 23; i++) pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (now_t !== 24'h235900 || mode !== 2'd2) begin
      n_bad++; $display("FAIL set_23_59 got %h mode %0d want 235900 mode 2", now_t, mode);
    end
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (now_t !== 24'h235959 || mode !== 2'd0) begin
      n_bad++; $display("FAIL run_to_235959 got %h mode %0d want 235959 mode 0", now_t, mode);
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (now_t !== 24'h000000) begin
      n_bad++; $display("FAIL day_rollover got %h want 000000", now_t);
    end
  endtask

  task automatic test_mode_sequence;
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (now_t !== 24'h000000 || mode !== 2'd1) begin
      n_bad++; $display("FAIL seq_set_h got %h mode %0d want 000000 mode 1", now_t, mode);
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (now_t !== 24'h000000) begin
      n_bad++; $display("FAIL frozen_set_h got %h want 000000", now_t);
    end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (now_t !== 24'h000000 || mode !== 2'd2) begin
      n_bad++; $display("FAIL frozen_set_m got %h mode %0d want 000000 mode 2", now_t, mode);
    end
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (now_t !== 24'h000000 || mode !== 2'd0) begin
      n_bad++; $display("FAIL back_to_run got %h mode %0d want 000000 mode 0", now_t, mode);
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (now_t !== 24'h000001) begin
      n_bad++; $display("FAIL resume_count got %h want 000001", now_t);
    end
  endtask

  task automatic test_hour_wrap;
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (now_t !== 24'h010000 || mode !== 2'd1) begin
      n_bad++; $display("FAIL hour_wrap got %h mode %0d want 010000 mode 1", now_t, mode);
    end
  endtask

  task automatic test_simultaneous;
    pulse(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (now_t !== 24'h010000 || mode !== 2'd2) begin
      n_bad++; $display("FAIL mode_beats_inc got %h mode %0d want 010000 mode 2", now_t, mode);
    end
    pulse(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (now_t !== 24'h010100) begin
      n_bad++; $display("FAIL inc_beats_tick got %h want 010100", now_t);
    end
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (now_t !== 24'h010104 || mode !== 2'd0) begin
      n_bad++; $display("FAIL run_after_set got %h mode %0d want 010104 mode 0", now_t, mode);
    end
    pulse(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (now_t !== 24'h010100 || mode !== 2'd1) begin
      n_bad++; $display("FAIL mode_beats_tick got %h mode %0d want 010100 mode 1", now_t, mode);
    end
  endtask

  task automatic test_held_pulse;
    // from SET_H 01:01:00: held btn_inc counts once per cycle
    btn_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    n_cmp++;
    if (now_t !== 24'h040100) begin
      n_bad++; $display("FAIL held_inc got %h want 040100", now_t);
    end
    for (int i = 0; i < 8; i++) pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 33; i++) pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (now_t !== 24'h123400 || mode !== 2'd2) begin
      n_bad++; $display("FAIL set_12_34 got %h mode %0d want 123400 mode 2", now_t, mode);
    end
  endtask

  task automatic test_async_reset;
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (now_t !== 24'h000000 || mode !== 2'd0) begin
      n_bad++; $display("FAIL async_reset got %h mode %0d want 000000 mode 0", now_t, mode);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    n_cmp++;
    if (now_t !== 24'h000002 || mode !== 2'd0) begin
      n_bad++; $display("FAIL after_reset got %h mode %0d want 000002 mode 0", now_t, mode);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_set_and_rollover();
    test_mode_sequence();
    test_hour_wrap();
    test_simultaneous();
    test_held_pulse();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
